// File: rtl/game_controller_n_if.sv
// Move handshake and board-memory write bus for the turn-sequencing controller.
// The master side is the player/memory environment; the slave side is the controller.
interface game_controller_n_if #(
    parameter int ADDRW = 4,
    parameter int CELLW = 2
);
    logic             move_valid;
    logic [ADDRW-1:0] move_addr;
    logic             move_ack;
    logic             move_nack;
    logic             mem_we;
    logic [ADDRW-1:0] mem_addr;
    logic [CELLW-1:0] mem_data;

    modport master (
        output move_valid, move_addr,
        input  move_ack, move_nack, mem_we, mem_addr, mem_data
    );

    modport slave (
        input  move_valid, move_addr,
        output move_ack, move_nack, mem_we, mem_addr, mem_data
    );
endinterface

// File: rtl/game_controller_n.sv
// Turn-sequencing FSM for N-player board games: clears the board, accepts or rejects
// moves, skips timed-out turns, counts moves and detects a full-board draw.
module game_controller_n #(
    parameter int NPLAYERS = 2,
    parameter int CELLS    = 9,
    parameter int ADDRW    = 4,
    parameter int CELLW    = 2,
    parameter int TIMEOUT  = 0,
    parameter int TOW      = 16,
    localparam int PW      = (NPLAYERS > 2) ? $clog2(NPLAYERS) : 1,
    localparam int CW      = $clog2(CELLS + 1)
) (
    input  logic                   ph1,
    input  logic                   reset,
    input  logic                   start,
    input  logic [PW-1:0]          first_player,
    input  logic [CELLS*CELLW-1:0] board,
    input  logic                   game_done,
    input  logic [CELLW-1:0]       winner,
    game_controller_n_if.slave     mv,
    output logic                   timeout_pulse,
    output logic [PW-1:0]          cur_player,
    output logic [CW-1:0]          move_count,
    output logic [CELLW-1:0]       result,
    output logic [2:0]             state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_TURN   = 3'd2,
        S_COMMIT = 3'd3,
        S_END    = 3'd4
    } state_t;

    localparam logic [TOW-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : TOW'(TIMEOUT - 1);

    state_t           state_r;
    logic             mem_we_r;
    logic [ADDRW-1:0] mem_addr_r;
    logic [CELLW-1:0] mem_data_r;
    logic             move_ack_r;
    logic             move_nack_r;
    logic             timeout_r;
    logic [PW-1:0]    cur_player_r;
    logic [CW-1:0]    move_count_r;
    logic [CELLW-1:0] result_r;
    logic [TOW-1:0]   timer_r;

    logic [CELLW-1:0] cell_s;
    logic             legal_s;
    logic [PW-1:0]    next_player_s;
    logic             restart_s;

    // Decode the addressed board cell, move legality and the next player in turn order.
    always_comb begin
        cell_s = '0;
        for (int i = 0; i < CELLS; i++) begin
            cell_s = (mv.move_addr == ADDRW'(i)) ? board[i*CELLW +: CELLW] : cell_s;
        end
        legal_s = (mv.move_addr < ADDRW'(CELLS)) && (cell_s == '0);
        if (cur_player_r == PW'(NPLAYERS - 1)) begin
            next_player_s = '0;
        end else begin
            next_player_s = cur_player_r + PW'(1);
        end
        // CLEAR runs to completion; start is honoured everywhere else.
        restart_s = start && (state_r != S_CLEAR);
    end

    // Single-process FSM; every output is registered and pulses default low each cycle.
    always_ff @(posedge ph1 or posedge reset) begin
        if (reset) begin
            state_r      <= S_IDLE;
            mem_we_r     <= 1'b0;
            mem_addr_r   <= '0;
            mem_data_r   <= '0;
            move_ack_r   <= 1'b0;
            move_nack_r  <= 1'b0;
            timeout_r    <= 1'b0;
            cur_player_r <= '0;
            move_count_r <= '0;
            result_r     <= '0;
            timer_r      <= '0;
        end else begin
            mem_we_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_data_r  <= '0;
            move_ack_r  <= 1'b0;
            move_nack_r <= 1'b0;
            timeout_r   <= 1'b0;
            if (restart_s) begin
                state_r      <= S_CLEAR;
                mem_we_r     <= 1'b1;
                cur_player_r <= first_player;
                move_count_r <= '0;
                result_r     <= '0;
                timer_r      <= '0;
            end else begin
                case (state_r)
                    S_IDLE: begin
                        state_r <= S_IDLE;
                    end
                    S_CLEAR: begin
                        if (mem_addr_r == ADDRW'(CELLS - 1)) begin
                            state_r <= S_TURN;
                        end else begin
                            mem_we_r   <= 1'b1;
                            mem_addr_r <= mem_addr_r + ADDRW'(1);
                        end
                    end
                    S_TURN: begin
                        if (game_done) begin
                            state_r  <= S_END;
                            result_r <= winner;
                        end else if (mv.move_valid && legal_s) begin
                            state_r    <= S_COMMIT;
                            mem_we_r   <= 1'b1;
                            mem_addr_r <= mv.move_addr;
                            mem_data_r <= CELLW'(cur_player_r) + CELLW'(1);
                            move_ack_r <= 1'b1;
                        end else if (mv.move_valid) begin
                            // Rejected move holds the timer so expiry still fires next cycle.
                            move_nack_r <= 1'b1;
                        end else if ((TIMEOUT != 0) && (timer_r == TO_LAST)) begin
                            timeout_r    <= 1'b1;
                            cur_player_r <= next_player_s;
                            timer_r      <= '0;
                        end else begin
                            timer_r <= timer_r + TOW'(1);
                        end
                    end
                    S_COMMIT: begin
                        move_count_r <= move_count_r + CW'(1);
                        cur_player_r <= next_player_s;
                        timer_r      <= '0;
                        if (move_count_r + CW'(1) == CW'(CELLS)) begin
                            state_r  <= S_END;
                            result_r <= '0;
                        end else begin
                            state_r <= S_TURN;
                        end
                    end
                    S_END: begin
                        state_r <= S_END;
                    end
                    default: begin
                        state_r <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign mv.mem_we     = mem_we_r;
    assign mv.mem_addr   = mem_addr_r;
    assign mv.mem_data   = mem_data_r;
    assign mv.move_ack   = move_ack_r;
    assign mv.move_nack  = move_nack_r;
    assign timeout_pulse = timeout_r;
    assign cur_player    = cur_player_r;
    assign move_count    = move_count_r;
    assign result        = result_r;
    assign state         = state_r;

endmodule

// File: tb/tb_game_controller_n.sv
// Directed bench for game_controller_n (2 players, 9 cells, 8-cycle turn timeout)
// with a behavioural board memory fed by the controller's write bus.
module tb_game_controller_n;

    logic        ph1;
    logic        reset;
    logic        start;
    logic [0:0]  first_player;
    logic [17:0] board;
    logic        game_done;
    logic [1:0]  winner;
    logic        timeout_pulse;
    logic [0:0]  cur_player;
    logic [3:0]  move_count;
    logic [1:0]  result;
    logic [2:0]  state;

    int vecs = 0;
    int errs = 0;

    game_controller_n_if #(.ADDRW(4), .CELLW(2)) mv ();

    game_controller_n #(
        .NPLAYERS(2), .CELLS(9), .ADDRW(4), .CELLW(2), .TIMEOUT(8), .TOW(16)
    ) dut (
        .ph1           (ph1),
        .reset         (reset),
        .start         (start),
        .first_player  (first_player),
        .board         (board),
        .game_done     (game_done),
        .winner        (winner),
        .mv            (mv),
        .timeout_pulse (timeout_pulse),
        .cur_player    (cur_player),
        .move_count    (move_count),
        .result        (result),
        .state         (state)
    );

    initial ph1 = 1'b0;
    always #5 ph1 = ~ph1;

    // Board memory model: written by the controller, read back as the board bus.
    always @(posedge ph1 or posedge reset) begin
        if (reset) begin
            board <= '0;
        end else if (mv.mem_we && (mv.mem_addr < 4'd9)) begin
            board[int'(mv.mem_addr)*2 +: 2] <= mv.mem_data;
        end
    end

    task automatic step();
        @(negedge ph1);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        vecs++;
        if ({state, mv.mem_we, mv.mem_addr, mv.mem_data, mv.move_ack, mv.move_nack,
             timeout_pulse, cur_player, move_count, result} !== 20'd0) begin
            errs++;
            $display("FAIL reset_state: state=%0d we=%0b cur=%0d cnt=%0d res=%0d, required all 0",
                     state, mv.mem_we, cur_player, move_count, result);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_clear(input logic [0:0] fp);
        start = 1'b1;
        first_player = fp;
        step();
        start = 1'b0;
        for (int i = 0; i < 9; i++) begin
            vecs++;
            if ({state, mv.mem_we, mv.mem_addr, mv.mem_data} !== {3'd1, 1'b1, 4'(i), 2'd0}) begin
                errs++;
                $display("FAIL clear_write[%0d]: state=%0d we=%0b addr=%0d data=%0d, required 1 1 %0d 0",
                         i, state, mv.mem_we, mv.mem_addr, mv.mem_data, i);
            end
            step();
        end
        vecs++;
        if ({state, mv.mem_we, cur_player, move_count} !== {3'd2, 1'b0, fp, 4'd0}) begin
            errs++;
            $display("FAIL clear_done: state=%0d we=%0b cur=%0d cnt=%0d, required 2 0 %0d 0",
                     state, mv.mem_we, cur_player, move_count, fp);
        end
    endtask

    task automatic test_move();
        mv.move_valid = 1'b1;
        mv.move_addr = 4'd4;
        step();
        mv.move_valid = 1'b0;
        vecs++;
        if ({state, mv.mem_we, mv.mem_addr, mv.mem_data, mv.move_ack} !== {3'd3, 1'b1, 4'd4, 2'd2, 1'b1}) begin
            errs++;
            $display("FAIL move_commit: state=%0d we=%0b addr=%0d data=%0d ack=%0b, required 3 1 4 2 1",
                     state, mv.mem_we, mv.mem_addr, mv.mem_data, mv.move_ack);
        end
        step();
        vecs++;
        if ({state, mv.mem_we, mv.move_ack, cur_player, move_count} !== {3'd2, 1'b0, 1'b0, 1'b0, 4'd1}) begin
            errs++;
            $display("FAIL move_after: state=%0d we=%0b ack=%0b cur=%0d cnt=%0d, required 2 0 0 0 1",
                     state, mv.mem_we, mv.move_ack, cur_player, move_count);
        end
    endtask

    task automatic test_reject();
        logic [3:0] bad [2] = '{4'd4, 4'd9};
        for (int i = 0; i < 2; i++) begin
            mv.move_valid = 1'b1;
            mv.move_addr = bad[i];
            step();
            vecs++;
            if ({state, mv.move_nack, mv.move_ack, mv.mem_we, cur_player} !== {3'd2, 1'b1, 1'b0, 1'b0, 1'b0}) begin
                errs++;
                $display("FAIL reject[addr %0d]: state=%0d nack=%0b ack=%0b we=%0b cur=%0d, required 2 1 0 0 0",
                         bad[i], state, mv.move_nack, mv.move_ack, mv.mem_we, cur_player);
            end
        end
        mv.move_valid = 1'b0;
    endtask

    task automatic test_timeout();
        int early = 0;
        for (int i = 0; i < 7; i++) begin
            step();
            if (timeout_pulse !== 1'b0) early++;
        end
        step();
        vecs++;
        if ({early[3:0], timeout_pulse, cur_player} !== {4'd0, 1'b1, 1'b1}) begin
            errs++;
            $display("FAIL timeout_skip: early=%0d pulse=%0b cur=%0d, required 0 1 1",
                     early, timeout_pulse, cur_player);
        end
        for (int i = 0; i < 7; i++) begin
            step();
            if (timeout_pulse !== 1'b0) early++;
        end
        mv.move_valid = 1'b1;
        mv.move_addr = 4'd0;
        step();
        mv.move_valid = 1'b0;
        vecs++;
        if ({early[3:0], timeout_pulse, mv.move_ack, mv.mem_we, mv.mem_addr, mv.mem_data} !==
            {4'd0, 1'b0, 1'b1, 1'b1, 4'd0, 2'd2}) begin
            errs++;
            $display("FAIL timeout_move_wins: early=%0d pulse=%0b ack=%0b we=%0b addr=%0d data=%0d, required 0 0 1 1 0 2",
                     early, timeout_pulse, mv.move_ack, mv.mem_we, mv.mem_addr, mv.mem_data);
        end
        step();
        vecs++;
        if ({timeout_pulse, cur_player, move_count} !== {1'b0, 1'b0, 4'd2}) begin
            errs++;
            $display("FAIL timeout_after: pulse=%0b cur=%0d cnt=%0d, required 0 0 2",
                     timeout_pulse, cur_player, move_count);
        end
    endtask

    task automatic test_done();
        game_done = 1'b1;
        winner = 2'd2;
        mv.move_valid = 1'b1;
        mv.move_addr = 4'd1;
        step();
        game_done = 1'b0;
        winner = 2'd0;
        mv.move_valid = 1'b0;
        vecs++;
        if ({state, result, mv.mem_we, mv.move_ack, mv.move_nack} !== {3'd4, 2'd2, 1'b0, 1'b0, 1'b0}) begin
            errs++;
            $display("FAIL done_end: state=%0d res=%0d we=%0b ack=%0b nack=%0b, required 4 2 0 0 0",
                     state, result, mv.mem_we, mv.move_ack, mv.move_nack);
        end
        step();
        vecs++;
        if ({state, result} !== {3'd4, 2'd2}) begin
            errs++;
            $display("FAIL done_hold: state=%0d res=%0d, required 4 2", state, result);
        end
        test_clear(1'b0);
    endtask

    task automatic test_full_board();
        for (int i = 0; i < 9; i++) begin
            mv.move_valid = 1'b1;
            mv.move_addr = 4'(i);
            step();
            mv.move_valid = 1'b0;
            vecs++;
            if ({mv.move_ack, mv.mem_addr, mv.mem_data} !== {1'b1, 4'(i), 2'((i % 2) + 1)}) begin
                errs++;
                $display("FAIL full_move[%0d]: ack=%0b addr=%0d data=%0d, required 1 %0d %0d",
                         i, mv.move_ack, mv.mem_addr, mv.mem_data, i, (i % 2) + 1);
            end
            step();
        end
        vecs++;
        if ({state, result, move_count, cur_player} !== {3'd4, 2'd0, 4'd9, 1'b1}) begin
            errs++;
            $display("FAIL full_draw: state=%0d res=%0d cnt=%0d cur=%0d, required 4 0 9 1",
                     state, result, move_count, cur_player);
        end
    endtask

    task automatic test_reset_mid_clear();
        start = 1'b1;
        first_player = 1'b1;
        step();
        start = 1'b0;
        step();
        vecs++;
        if ({state, mv.mem_addr} !== {3'd1, 4'd1}) begin
            errs++;
            $display("FAIL midclear_pre: state=%0d addr=%0d, required 1 1", state, mv.mem_addr);
        end
        reset = 1'b1;
        #1;
        vecs++;
        if ({state, mv.mem_we, mv.mem_addr, mv.mem_data, mv.move_ack, mv.move_nack,
             timeout_pulse, cur_player, move_count, result} !== 20'd0) begin
            errs++;
            $display("FAIL midclear_reset: state=%0d we=%0b addr=%0d cur=%0d cnt=%0d, required all 0",
                     state, mv.mem_we, mv.mem_addr, cur_player, move_count);
        end
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        first_player = 1'b0;
        game_done = 1'b0;
        winner = 2'd0;
        mv.move_valid = 1'b0;
        mv.move_addr = 4'd0;
        test_reset();
        test_clear(1'b1);
        test_move();
        test_reject();
        test_timeout();
        test_done();
        test_full_board();
        test_reset_mid_clear();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
